// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider serving DIV/DIVU beside the ALU
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic               stall,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [2*WIDTH:0] work;
    logic [2*WIDTH:0] work_shl;
    logic [2*WIDTH:0] work_nxt;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quo_fix;
    logic             qsign;
    logic             rsign;
    logic             b_zero;
    logic             accept;
    logic             step;
    logic             finish_div;
    logic             finish_zero;

    assign b_zero = (b == '0);
    assign mag_a  = (signed_div && a[WIDTH-1]) ? -a : a;
    assign mag_b  = (signed_div && b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !annul) begin
                    state_nxt = b_zero ? DIVZERO : ON;
                end
            end
            DIVZERO: state_nxt = annul ? IDLE : END;
            ON: begin
                if (annul) begin
                    state_nxt = IDLE;
                end else if (count == LAST) begin
                    state_nxt = END;
                end
            end
            END:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept      = 1'b0;
        step        = 1'b0;
        finish_div  = 1'b0;
        finish_zero = 1'b0;
        case (state)
            IDLE:    accept = start & ~annul;
            DIVZERO: finish_zero = ~annul;
            ON: begin
                step       = ~annul;
                finish_div = ~annul & (count == LAST);
            end
            default: ;
        endcase
        stall = accept | (((state == DIVZERO) || (state == ON)) & ~annul);
    end

    // Upper WIDTH+1 bits hold the partial remainder; a borrow in diff[WIDTH] restores.
    always_comb begin
        work_shl = work << 1;
        diff     = work_shl[2*WIDTH:WIDTH] - {1'b0, divisor};
        work_nxt = diff[WIDTH] ? work_shl : {diff, work_shl[WIDTH-1:1], 1'b1};
        rem_fix  = rsign ? -work_nxt[2*WIDTH-1:WIDTH] : work_nxt[2*WIDTH-1:WIDTH];
        quo_fix  = qsign ? -work_nxt[WIDTH-1:0] : work_nxt[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work    <= '0;
            divisor <= '0;
            qsign   <= 1'b0;
            rsign   <= 1'b0;
            count   <= '0;
            ready   <= 1'b0;
            result  <= '0;
        end else begin
            ready <= finish_div | finish_zero;
            if (accept) begin
                // A zero divisor keeps the raw dividend so it can be returned in HI.
                work    <= {{(WIDTH+1){1'b0}}, (b_zero ? a : mag_a)};
                divisor <= mag_b;
                qsign   <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                rsign   <= signed_div & a[WIDTH-1];
                count   <= '0;
            end else if (step) begin
                work  <= work_nxt;
                count <= count + 1'b1;
            end
            if (finish_div) begin
                result <= {rem_fix, quo_fix};
            end else if (finish_zero) begin
                result <= {work[WIDTH-1:0], {WIDTH{1'b1}}};
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed-vector bench for div_unit
module tb_div_unit;
    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        stall;
    logic        ready;
    logic [63:0] result;

    int total;
    int bad;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .stall      (stall),
        .ready      (ready),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic sd, input logic [31:0] av,
                           input logic [31:0] bv, input logic [63:0] exp, input int exp_lat);
        int   lat;
        logic stall_gap;
        signed_div = sd;
        a          = av;
        b          = bv;
        start      = 1'b1;
        #1;
        check({tag, "_stall_req"}, 64'(stall), 64'd1);
        lat       = 0;
        stall_gap = 1'b0;
        do begin
            tick();
            lat++;
            if (!ready && !stall) stall_gap = 1'b1;
        end while (!ready && lat < 60);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, result, exp);
        check({tag, "_stall_end"}, 64'(stall), 64'd0);
        check({tag, "_stall_gap"}, 64'(stall_gap), 64'd0);
        start = 1'b0;
        tick();
        check({tag, "_ready_drop"}, 64'(ready), 64'd0);
        check({tag, "_held"}, result, exp);
    endtask

    initial begin
        int t1;
        int t2;
        int nready;
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        a          = '0;
        b          = '0;
        annul      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_stall", 64'(stall), 64'd0);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        run_div("divu_by0", 1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 2);
        run_div("div_minneg", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
        run_div("divu_minneg", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33);

        // annul while iterating: back to IDLE, no pulse, result kept
        signed_div = 1'b0;
        a          = 32'd100;
        b          = 32'd7;
        start      = 1'b1;
        repeat (10) tick();
        annul = 1'b1;
        #1;
        check("anl_stall_low", 64'(stall), 64'd0);
        tick();
        check("anl_no_ready", 64'(ready), 64'd0);
        annul = 1'b0;
        start = 1'b0;
        #1;
        check("anl_idle", 64'(stall), 64'd0);
        check("anl_keep", result, {32'h8000_0000, 32'h0});
        run_div("anl_new", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // annul in IDLE blocks acceptance
        annul = 1'b1;
        start = 1'b1;
        b     = 32'd5;
        #1;
        check("idle_anl_stall", 64'(stall), 64'd0);
        tick();
        annul = 1'b0;
        start = 1'b0;
        #1;
        check("idle_anl_stay", 64'(stall), 64'd0);

        // reset mid-division
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mrst_ready", 64'(ready), 64'd0);
        check("mrst_result", result, 64'd0);
        check("mrst_stall_start", 64'(stall), 64'd1);
        start = 1'b0;
        #1;
        check("mrst_stall_idle", 64'(stall), 64'd0);
        nready = 0;
        repeat (40) begin
            tick();
            if (ready) nready++;
        end
        check("mrst_no_ready", 64'(nready), 64'd0);

        // back-to-back with start held; operands change as the pipeline advances
        signed_div = 1'b0;
        a          = 32'd100;
        b          = 32'd7;
        start      = 1'b1;
        t1         = -1;
        t2         = -1;
        for (int i = 1; i <= 90 && t2 < 0; i++) begin
            tick();
            if (ready) begin
                if (t1 < 0) begin
                    t1 = i;
                    check("b2b_res1", result, {32'd2, 32'd14});
                    a = 32'd50;
                    b = 32'd6;
                end else begin
                    t2 = i;
                    check("b2b_res2", result, {32'd2, 32'd8});
                end
            end
        end
        check("b2b_first", 64'(t1), 64'd33);
        check("b2b_gap", 64'(t2 - t1), 64'd34);
        start = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
